// File: rtl/vid_stream_checker_if.sv
// vid_stream_if: AXI4-Stream video beat bundle between pixel source and sink
// tdata/tkeep : pixel payload and byte enables
// tuser       : start of frame
// tlast       : end of line
// tvalid      : source has a beat
// tready      : sink accepts the beat
// master modport is the source side, slave modport is the sink side
interface vid_stream_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tuser;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    modport master(output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave(input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/vid_stream_checker.sv
// vid_stream_checker: AXI4-Stream video sink with framing checks and status counters
// in_stream_aclk        : clock
// periph_reset          : asynchronous active-high reset
// in_stream             : slave side of the video stream, tready generated here
// err_clr               : synchronous clear of sof/eol/timeout counters
// x_pos, y_pos          : expected word and line of the next beat
// frame_cnt             : frames started
// sof_err_cnt           : SOF framing errors
// eol_err_cnt           : EOL framing errors
// timeout_cnt           : valid-starvation timeouts
// frame_done            : pulse after a correctly terminated last beat of a frame
// in_sync               : high while a frame is being tracked
module vid_stream_checker #(
    parameter int          X_SIZE     = 480,
    parameter int          Y_SIZE     = 480,
    parameter int          TIMEOUT    = 1000,
    parameter int          READY_MODE = 1,
    parameter logic [32:0] RND_SEED   = 33'h04A4C3D4A,
    parameter int          CNT_W      = 16
) (
    input  logic             in_stream_aclk,
    input  logic             periph_reset,
    vid_stream_if.slave      in_stream,
    input  logic             err_clr,
    output logic [15:0]      x_pos,
    output logic [15:0]      y_pos,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] sof_err_cnt,
    output logic [CNT_W-1:0] eol_err_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic             frame_done,
    output logic             in_sync
);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic {WAIT_SOF, IN_FRAME} state_t;

    state_t          state, state_n;
    logic [32:0]     prbs;
    logic            ready;
    logic [IW-1:0]   idle;
    logic            acc, at_origin, sof, keep, sof_err, eol_err, done, end_word, end_line, to_evt;
    logic [15:0]     xe, ye, x_n, y_n;
    logic            unused_payload;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && !(&c)) ? c + CNT_W'(1) : c;
    endfunction

    assign acc            = in_stream.tvalid && ready;
    assign in_stream.tready = ready;
    assign in_sync        = state == IN_FRAME;
    assign to_evt         = !in_stream.tvalid && idle == IW'(TIMEOUT - 1);
    assign unused_payload = ^{in_stream.tdata, in_stream.tkeep};

    always_comb begin
        state_n   = state;
        at_origin = x_pos == 16'd0 && y_pos == 16'd0;
        sof       = acc && in_stream.tuser;
        // a beat is tracked unless it is stray (outside a frame) or a missing SOF
        keep      = sof || (acc && state == IN_FRAME && !at_origin);
        sof_err   = acc && state == IN_FRAME && (in_stream.tuser != at_origin);
        // an SOF restarts the frame, so line-end rules see position (0,0)
        xe        = sof ? 16'd0 : x_pos;
        ye        = sof ? 16'd0 : y_pos;
        end_word  = xe == 16'(X_SIZE - 1);
        end_line  = end_word || in_stream.tlast;
        eol_err   = keep && (end_word != in_stream.tlast);
        done      = keep && end_word && in_stream.tlast && ye == 16'(Y_SIZE - 1);
        x_n       = !keep ? x_pos : end_line ? 16'd0 : xe + 16'd1;
        y_n       = !keep ? y_pos : !end_line ? ye : (ye == 16'(Y_SIZE - 1)) ? 16'd0 : ye + 16'd1;
        if (sof)
            state_n = IN_FRAME;
        else if (sof_err)
            state_n = WAIT_SOF;
    end

    always_ff @(posedge in_stream_aclk or posedge periph_reset)
        if (periph_reset)
            state <= WAIT_SOF;
        else
            state <= state_n;

    always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            prbs        <= RND_SEED;
            ready       <= 1'b0;
            idle        <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            frame_cnt   <= '0;
            sof_err_cnt <= '0;
            eol_err_cnt <= '0;
            timeout_cnt <= '0;
            frame_done  <= 1'b0;
        end else begin
            prbs        <= {prbs[31:0], prbs[32] ^ ~prbs[19]};
            ready       <= READY_MODE == 1 ? 1'b1 : READY_MODE == 2 ? prbs[32] : in_stream.tvalid && !ready;
            idle        <= (in_stream.tvalid || to_evt) ? '0 : idle + IW'(1);
            x_pos       <= x_n;
            y_pos       <= y_n;
            frame_cnt   <= sat_inc(frame_cnt, sof);
            sof_err_cnt <= err_clr ? '0 : sat_inc(sof_err_cnt, sof_err);
            eol_err_cnt <= err_clr ? '0 : sat_inc(eol_err_cnt, eol_err);
            timeout_cnt <= err_clr ? '0 : sat_inc(timeout_cnt, to_evt);
            frame_done  <= done;
        end
    end
endmodule

// File: tb/tb_vid_stream_checker.sv
// tb_vid_stream_checker: checks three sinks (ready modes 1, 2, 3) on a 4x3 frame geometry
module tb_vid_stream_checker;
    localparam int X = 4, Y = 3, TO = 10;

    logic clk = 0, rst = 0, v = 0, u = 0, l = 0, clr = 0;
    logic [31:0] dat = 0;
    logic [15:0] xp[3], yp[3], fc[3], sc[3], ec[3], tc[3];
    logic fd[3], sy[3], rd[3];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g
        vid_stream_if s ();
        assign s.tdata  = dat;
        assign s.tkeep  = 4'hf;
        assign s.tuser  = u;
        assign s.tlast  = l;
        assign s.tvalid = v;
        assign rd[i]    = s.tready;
        vid_stream_checker #(.X_SIZE(X), .Y_SIZE(Y), .TIMEOUT(TO), .READY_MODE(i + 1)) u_dut (
            .in_stream_aclk(clk), .periph_reset(rst), .in_stream(s), .err_clr(clr),
            .x_pos(xp[i]), .y_pos(yp[i]), .frame_cnt(fc[i]), .sof_err_cnt(sc[i]),
            .eol_err_cnt(ec[i]), .timeout_cnt(tc[i]), .frame_done(fd[i]), .in_sync(sy[i]));
    end

    // reference model: position kept as a linear word index inside the frame
    int mpos[2], mframe[2], msof[2], meol[2], mto[2], midle[2];
    bit msync[2], mdone[2], mrdy[2];
    logic [32:0] mprbs;

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            mpos[k] = 0; mframe[k] = 0; msof[k] = 0; meol[k] = 0; mto[k] = 0;
            midle[k] = 0; msync[k] = 0; mdone[k] = 0; mrdy[k] = 0;
        end
        mprbs = 33'h04A4C3D4A;
    endtask

    function automatic int sat(input int c);
        return c < 65535 ? c + 1 : c;
    endfunction

    task automatic step(input int k);
        bit use_beat, serr;
        int col, line;
        mdone[k] = 0;
        if (v && mrdy[k]) begin
            use_beat = 1; serr = 0;
            if (u) begin
                if (msync[k] && mpos[k] != 0) serr = 1;
                mpos[k] = 0; msync[k] = 1; mframe[k] = sat(mframe[k]);
            end else if (!msync[k]) use_beat = 0;
            else if (mpos[k] == 0) begin serr = 1; msync[k] = 0; use_beat = 0; end
            if (use_beat) begin
                col = mpos[k] % X; line = mpos[k] / X;
                if (col == X - 1 || l) begin
                    if ((col == X - 1) != l) meol[k] = sat(meol[k]);
                    if (col == X - 1 && l && line == Y - 1) mdone[k] = 1;
                    mpos[k] = ((line + 1) % Y) * X;
                end else mpos[k]++;
            end
            if (serr) msof[k] = sat(msof[k]);
        end
        if (v) midle[k] = 0;
        else if (++midle[k] == TO) begin midle[k] = 0; mto[k] = sat(mto[k]); end
        if (clr) begin msof[k] = 0; meol[k] = 0; mto[k] = 0; end
        if (k == 0) mrdy[k] = 1;
        else begin mrdy[k] = mprbs[32]; mprbs = {mprbs[31:0], mprbs[32] ^ ~mprbs[19]}; end
    endtask

    task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d got %0d want %0d at %0t", n, k, a, e, $time);
        end
    endtask

    task automatic compare(input int k);
        chk("x_pos", k, xp[k], mpos[k] % X);
        chk("y_pos", k, yp[k], mpos[k] / X);
        chk("frame_cnt", k, fc[k], mframe[k]);
        chk("sof_err_cnt", k, sc[k], msof[k]);
        chk("eol_err_cnt", k, ec[k], meol[k]);
        chk("timeout_cnt", k, tc[k], mto[k]);
        chk("frame_done", k, fd[k], mdone[k]);
        chk("in_sync", k, sy[k], msync[k]);
        chk("tready", k, rd[k], mrdy[k]);
    endtask

    task automatic chk_zero(input string n);
        for (int k = 0; k < 3; k++) begin
            chk({n, "_x"}, k, xp[k], 0); chk({n, "_y"}, k, yp[k], 0);
            chk({n, "_frame"}, k, fc[k], 0); chk({n, "_sof"}, k, sc[k], 0);
            chk({n, "_eol"}, k, ec[k], 0); chk({n, "_to"}, k, tc[k], 0);
            chk({n, "_done"}, k, fd[k], 0); chk({n, "_sync"}, k, sy[k], 0);
            chk({n, "_ready"}, k, rd[k], 0);
        end
    endtask

    task automatic cyc(input logic nv, nu, nl, nc);
        v = nv; u = nu; l = nl; clr = nc; dat = $urandom;
        @(posedge clk);
        step(0); step(1);
        #1;
        compare(0); compare(1);
    endtask

    typedef struct {
        logic v, u, l, c;
        int x, y, f, s, e, d, sy;
    } vec_t;
    vec_t tbl[17];

    initial begin
        int ndone;
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 0, 0, 2, 1, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 0, 1, 0, 3, 1, 0, 0, 1};
        tbl[5]  = '{1, 0, 1, 0, 0, 1, 3, 1, 1, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 1, 1, 3, 1, 1, 0, 1};
        tbl[7]  = '{1, 0, 0, 0, 2, 1, 3, 1, 1, 0, 1};
        tbl[8]  = '{1, 0, 0, 0, 3, 1, 3, 1, 1, 0, 1};
        tbl[9]  = '{1, 0, 0, 0, 0, 2, 3, 1, 2, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 2, 3, 1, 2, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 1, 2, 3, 1, 2, 0, 1};
        tbl[12] = '{1, 0, 0, 0, 2, 2, 3, 1, 2, 0, 1};
        tbl[13] = '{1, 1, 0, 0, 1, 0, 4, 2, 2, 0, 1};
        tbl[14] = '{1, 0, 1, 1, 0, 1, 4, 0, 0, 0, 1};
        tbl[15] = '{1, 1, 1, 0, 0, 1, 5, 1, 1, 0, 1};
        tbl[16] = '{1, 0, 0, 0, 1, 1, 5, 1, 1, 0, 1};

        #1 rst = 1;
        #2 chk_zero("reset");
        mreset();
        @(posedge clk); @(posedge clk); #1 rst = 0;

        cyc(0, 0, 0, 0);
        ndone = 0;
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < X * Y; b++) begin
                cyc(1, b == 0, b % X == X - 1, 0);
                ndone += int'(fd[0]);
            end
        chk("clean_done_pulses", 0, ndone, 2);
        chk("clean_frames", 0, fc[0], 2);
        chk("clean_errs", 0, sc[0] + ec[0] + tc[0], 0);
        chk("clean_pos", 0, {xp[0], yp[0]}, 0);

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].v, tbl[i].u, tbl[i].l, tbl[i].c);
            chk($sformatf("tbl%0d_x", i), 0, xp[0], tbl[i].x);
            chk($sformatf("tbl%0d_y", i), 0, yp[0], tbl[i].y);
            chk($sformatf("tbl%0d_frame", i), 0, fc[0], tbl[i].f);
            chk($sformatf("tbl%0d_sof", i), 0, sc[0], tbl[i].s);
            chk($sformatf("tbl%0d_eol", i), 0, ec[0], tbl[i].e);
            chk($sformatf("tbl%0d_done", i), 0, fd[0], tbl[i].d);
            chk($sformatf("tbl%0d_sync", i), 0, sy[0], tbl[i].sy);
        end

        for (int i = 0; i < 25; i++) cyc(0, 0, 0, 0);
        chk("timeout_25", 0, tc[0], 2);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        chk("timeout_29", 0, tc[0], 2);
        cyc(0, 0, 0, 1);
        chk("timeout_clr", 0, tc[0], 0);

        #2 rst = 1;
        #1 chk_zero("rst2");
        mreset();
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1, i < 2, 0, 0);
            chk($sformatf("m3_ready%0d", i), 2, rd[2], i % 2 == 0);
            chk($sformatf("m3_x%0d", i), 2, xp[2], (i + 1) / 2);
            chk($sformatf("m3_frame%0d", i), 2, fc[2], i >= 1);
        end
        #2 rst = 1;
        #1 chk_zero("midline_rst");
        mreset();
        v = 0;
        @(posedge clk); #1 rst = 0;

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) == 0)
                for (int j = 0; j < 12; j++) cyc(0, 0, 0, 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
